// File: rtl/sfr_rmw_master.sv
// sfr_rmw_master: performs single SFR bus transactions on behalf of a core.
// Plain reads and writes, single-bit set/clear/complement, and byte-wide
// AND/OR/XOR. Each read-modify-write is done as one read cycle followed by
// one write cycle.
//
// Handshake: the core raises i_req with the operands valid. The request is
// accepted on the rising edge where the FSM is IDLE (o_busy=0) and i_req=1,
// and all operands are latched on that edge. While o_busy=1, i_req and every
// operand input are ignored; nothing is queued. o_done pulses for one cycle
// when the transaction finishes, and the next request can be accepted no
// earlier than the edge after that pulse.
module sfr_rmw_master #(
    parameter int ADDR_W = 7
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic [2:0]        i_op,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_bit_sel,
    input  logic [7:0]        i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [7:0]        o_rdata,
    output logic              o_bit_out,
    output logic [ADDR_W-1:0] o_sfr_address,
    output logic [7:0]        o_sfr_data,
    output logic              o_sfr_wren,
    output logic              o_sfr_rden,
    input  logic [7:0]        i_sfr_q,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_SETB  = 3'd2;
    localparam logic [2:0] OP_CLRB  = 3'd3;
    localparam logic [2:0] OP_CPLB  = 3'd4;
    localparam logic [2:0] OP_ANL   = 3'd5;
    localparam logic [2:0] OP_ORL   = 3'd6;
    localparam logic [2:0] OP_XRL   = 3'd7;

    state_t            r_state;
    state_t            w_next_state;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_bit_sel;
    logic [7:0]        r_wdata;
    logic [7:0]        r_rdata;
    logic              r_bit_out;
    logic [7:0]        w_bit_mask;
    logic [7:0]        w_mod_data;
    logic              w_accept;

    assign w_accept   = (r_state == S_IDLE) && i_req;
    assign w_bit_mask = 8'd1 << r_bit_sel;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand latch on accept, and read-data / bit capture at the end of RD.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_op      <= 3'd0;
            r_addr    <= '0;
            r_bit_sel <= 3'd0;
            r_wdata   <= 8'h00;
            r_rdata   <= 8'h00;
            r_bit_out <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op      <= i_op;
                r_addr    <= i_addr;
                r_bit_sel <= i_bit_sel;
                r_wdata   <= i_wdata;
            end
            if (r_state == S_RD) begin
                r_rdata   <= i_sfr_q;
                r_bit_out <= i_sfr_q[r_bit_sel];
            end
        end
    end

    // Value driven during the write cycle, derived from the latched operation.
    always_comb begin
        w_mod_data = r_wdata;
        case (r_op)
            OP_WRITE: w_mod_data = r_wdata;
            OP_SETB:  w_mod_data = r_rdata | w_bit_mask;
            OP_CLRB:  w_mod_data = r_rdata & ~w_bit_mask;
            OP_CPLB:  w_mod_data = r_rdata ^ w_bit_mask;
            OP_ANL:   w_mod_data = r_rdata & r_wdata;
            OP_ORL:   w_mod_data = r_rdata | r_wdata;
            OP_XRL:   w_mod_data = r_rdata ^ r_wdata;
            default:  w_mod_data = r_wdata;
        endcase
    end

    // Next-state and bus strobes; read and write enables come from distinct
    // states so they can never overlap.
    always_comb begin
        w_next_state = r_state;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        o_sfr_rden   = 1'b0;
        o_sfr_wren   = 1'b0;
        o_sfr_data   = 8'h00;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_req) begin
                    w_next_state = (i_op == OP_WRITE) ? S_WR : S_RD;
                end
            end
            S_RD: begin
                o_sfr_rden   = 1'b1;
                w_next_state = (r_op == OP_READ) ? S_DONE : S_WR;
            end
            S_WR: begin
                o_sfr_wren   = 1'b1;
                o_sfr_data   = w_mod_data;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                o_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // The address register only loads on accept, so it holds through IDLE.
    assign o_sfr_address = r_addr;
    assign o_rdata       = r_rdata;
    assign o_bit_out     = r_bit_out;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_sfr_rmw_master.sv
// Bench for sfr_rmw_master: a byte-array SFR model on the bus, a table of
// directed transactions with hand-computed results, and hand-written
// sequences for reset behaviour, held-high requests and reset abort.
module tb_sfr_rmw_master;

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_SETB  = 3'd2;
    localparam logic [2:0] OP_CLRB  = 3'd3;
    localparam logic [2:0] OP_CPLB  = 3'd4;
    localparam logic [2:0] OP_ANL   = 3'd5;
    localparam logic [2:0] OP_ORL   = 3'd6;
    localparam logic [2:0] OP_XRL   = 3'd7;

    typedef struct {
        logic [2:0] op;
        logic [6:0] addr;
        logic [2:0] bit_sel;
        logic [7:0] wdata;
        logic [7:0] init;
        logic [7:0] exp_data;
        logic [7:0] exp_mem;
        logic [7:0] exp_rdata;
        logic       exp_bit;
        int         exp_lat;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [2:0] op;
    logic [6:0] addr;
    logic [2:0] bit_sel;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       bit_out;
    logic [6:0] sfr_address;
    logic [7:0] sfr_data;
    logic       sfr_wren;
    logic       sfr_rden;
    logic [7:0] sfr_q;
    logic [1:0] dbg_state;

    logic [7:0] sfr_mem [128];
    logic       pl_we;
    logic [6:0] pl_addr;
    logic [7:0] pl_val;

    int n_cmp;
    int n_bad;

    sfr_rmw_master #(.ADDR_W(7)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .i_op          (op),
        .i_addr        (addr),
        .i_bit_sel     (bit_sel),
        .i_wdata       (wdata),
        .o_busy        (busy),
        .o_done        (done),
        .o_rdata       (rdata),
        .o_bit_out     (bit_out),
        .o_sfr_address (sfr_address),
        .o_sfr_data    (sfr_data),
        .o_sfr_wren    (sfr_wren),
        .o_sfr_rden    (sfr_rden),
        .i_sfr_q       (sfr_q),
        .o_dbg_state   (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SFR model: bench preload has priority over bus writes.
    always @(posedge clk) begin
        if (pl_we) begin
            sfr_mem[pl_addr] <= pl_val;
        end else if (sfr_wren) begin
            sfr_mem[sfr_address] <= sfr_data;
        end
    end
    assign sfr_q = sfr_rden ? sfr_mem[sfr_address] : 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at a negedge one cycle later.
    task automatic preload(input logic [6:0] a, input logic [7:0] v);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_val  = v;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_rden"},  sfr_rden, 0);
        check({tag, "_wren"},  sfr_wren, 0);
        check({tag, "_bit"},   bit_out, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_addr"},  sfr_address, 0);
        check({tag, "_data"},  sfr_data, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // One transaction from IDLE; operand inputs are scrambled while busy.
    task automatic run_vec(input vec_t v);
        int   lat;
        int   rd_n;
        int   wr_n;
        logic seen_done;
        preload(v.addr, v.init);
        req     = 1'b1;
        op      = v.op;
        addr    = v.addr;
        bit_sel = v.bit_sel;
        wdata   = v.wdata;
        lat = 0; rd_n = 0; wr_n = 0; seen_done = 1'b0;
        for (int c = 1; c <= 8 && !seen_done; c++) begin
            @(negedge clk);
            check("overlap", {31'd0, sfr_rden & sfr_wren}, 0);
            check("busy_in_txn", busy, 1);
            check("addr_in_txn", sfr_address, v.addr);
            if (sfr_rden) rd_n++;
            if (sfr_wren) begin
                wr_n++;
                check("wr_data", sfr_data, v.exp_data);
            end else begin
                check("data_zero", sfr_data, 0);
            end
            if (done) begin
                seen_done = 1'b1;
                lat = c;
                check("rdata", rdata, v.exp_rdata);
                check("bit_out", bit_out, v.exp_bit);
                req = 1'b0;
            end else begin
                req     = 1'($urandom_range(0, 1));
                op      = 3'($urandom_range(0, 7));
                addr    = 7'($urandom_range(0, 127));
                bit_sel = 3'($urandom_range(0, 7));
                wdata   = 8'($urandom_range(0, 255));
            end
        end
        check("latency", lat, v.exp_lat);
        check("rd_cycles", rd_n, (v.op == OP_WRITE) ? 0 : 1);
        check("wr_cycles", wr_n, (v.op == OP_READ) ? 0 : 1);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_addr_hold", sfr_address, v.addr);
        check("mem_after", sfr_mem[v.addr], v.exp_mem);
    endtask

    vec_t vecs [10];
    vec_t post_abort;
    int   done_cnt;
    logic prev_done;
    logic prev_idle;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        // op, addr, bit, wdata, init, exp_data, exp_mem, exp_rdata, exp_bit, lat
        vecs[0] = '{OP_WRITE, 7'h10, 3'd0, 8'hA5, 8'h00, 8'hA5, 8'hA5, 8'h00, 1'b0, 2};
        vecs[1] = '{OP_READ,  7'h20, 3'd2, 8'h00, 8'h3C, 8'h00, 8'h3C, 8'h3C, 1'b1, 2};
        vecs[2] = '{OP_SETB,  7'h30, 3'd3, 8'h00, 8'h00, 8'h08, 8'h08, 8'h00, 1'b0, 3};
        vecs[3] = '{OP_CPLB,  7'h31, 3'd7, 8'h00, 8'hFF, 8'h7F, 8'h7F, 8'hFF, 1'b1, 3};
        vecs[4] = '{OP_ANL,   7'h00, 3'd0, 8'h3C, 8'hF0, 8'h30, 8'h30, 8'hF0, 1'b0, 3};
        vecs[5] = '{OP_ORL,   7'h00, 3'd1, 8'h3C, 8'hF0, 8'hFC, 8'hFC, 8'hF0, 1'b0, 3};
        vecs[6] = '{OP_XRL,   7'h00, 3'd4, 8'h3C, 8'hF0, 8'hCC, 8'hCC, 8'hF0, 1'b1, 3};
        vecs[7] = '{OP_WRITE, 7'h12, 3'd0, 8'h5A, 8'h00, 8'h5A, 8'h5A, 8'hF0, 1'b1, 2};
        vecs[8] = '{OP_CLRB,  7'h45, 3'd5, 8'h00, 8'hFF, 8'hDF, 8'hDF, 8'hFF, 1'b1, 3};
        vecs[9] = '{OP_READ,  7'h7F, 3'd7, 8'h00, 8'h80, 8'h00, 8'h80, 8'h80, 1'b1, 2};
        post_abort = '{OP_WRITE, 7'h51, 3'd0, 8'hC3, 8'h00, 8'hC3, 8'hC3, 8'h00, 1'b0, 2};

        // Reset with a request pending: it must be ignored.
        pl_we = 1'b0; pl_addr = 7'h00; pl_val = 8'h00;
        rst_n = 1'b0; req = 1'b1; op = OP_WRITE; addr = 7'h05; bit_sel = 3'd0; wdata = 8'h11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");

        // First accept happens on the first edge with rst_n high.
        rst_n = 1'b1;
        @(negedge clk);
        check("first_accept_busy", busy, 1);
        check("first_accept_wren", sfr_wren, 1);
        check("first_accept_data", sfr_data, 8'h11);
        req = 1'b0;
        @(negedge clk);
        check("first_accept_done", done, 1);
        @(negedge clk);
        check("first_accept_mem", sfr_mem[7'h05], 8'h11);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Request held high with the op alternating every cycle.
        preload(7'h40, 8'h0F);
        req = 1'b1; addr = 7'h40; wdata = 8'h33; bit_sel = 3'd0; op = OP_ORL;
        done_cnt = 0; prev_done = 1'b0; prev_idle = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("hold_overlap", {31'd0, sfr_rden & sfr_wren}, 0);
            if (prev_done) begin
                check("hold_idle_after_done", busy, 0);
                check("hold_single_done", done, 0);
            end
            if (prev_idle) check("hold_accept_after_idle", busy, 1);
            prev_idle = prev_done;
            prev_done = done;
            if (done) done_cnt++;
            op = (op == OP_ORL) ? OP_WRITE : OP_ORL;
        end
        check("hold_done_count_ok", {31'd0, done_cnt >= 8}, 1);
        req = 1'b0;
        for (int c = 0; c < 8 && busy; c++) @(negedge clk);
        check("hold_drained", busy, 0);

        // Reset during the read cycle of CLRB aborts it.
        preload(7'h50, 8'hFF);
        req = 1'b1; op = OP_CLRB; addr = 7'h50; bit_sel = 3'd1; wdata = 8'h00;
        @(negedge clk);
        check("abort_in_rd", sfr_rden, 1);
        rst_n = 1'b0; req = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_wren", sfr_wren, 0);
        check("abort_no_done", done, 0);
        check("abort_mem_kept", sfr_mem[7'h50], 8'hFF);
        run_vec(post_abort);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
